// File: rtl/load_store_unit.sv
// Load/store unit between the CPU and a word-addressed data memory: turns byte-addressed
// byte/half/word requests into word accesses, with read-modify-write for sub-word stores.
module load_store_unit #(
    parameter int MEM_BIT_WIDTH = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic        resp_error,
    output logic [31:0] mem_in_addr,
    output logic [31:0] mem_in_data,
    output logic        mem_in_valid,
    input  logic        mem_in_ready,
    output logic [31:0] mem_out_addr,
    output logic        mem_out_valid,
    input  logic [31:0] mem_out_data,
    input  logic        mem_out_ready
);

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        RMW_RD_WAIT,
        WR_WAIT,
        RESP
    } state_t;

    state_t      state;
    logic [1:0]  size_q;
    logic        signed_q;
    logic [1:0]  lane_q;
    logic [15:0] wdata_q;

    logic [29:0] word_idx;
    logic        size_illegal;
    logic        misaligned;
    logic        out_of_range;
    logic        req_error;

    assign req_ready    = (state == IDLE);
    assign word_idx     = req_addr[31:2];
    assign size_illegal = (req_size == 2'd3);
    assign misaligned   = ((req_size == 2'd1) && req_addr[0]) ||
                          ((req_size == 2'd2) && (req_addr[1:0] != 2'b00));
    assign out_of_range = ((word_idx >> MEM_BIT_WIDTH) != 30'd0);
    assign req_error    = size_illegal || misaligned || out_of_range;

    function automatic logic [31:0] extract_lane(input logic [31:0] word, input logic [1:0] size,
                                                 input logic sgn, input logic [1:0] lane);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            2'd0:    extract_lane = {{24{sgn & b[7]}}, b};
            2'd1:    extract_lane = {{16{sgn & h[15]}}, h};
            default: extract_lane = word;
        endcase
    endfunction

    function automatic logic [31:0] merge_lane(input logic [31:0] word, input logic [1:0] size,
                                               input logic [1:0] lane, input logic [15:0] wdata);
        logic [31:0] merged;
        merged = word;
        if (size == 2'd0) begin
            merged[{lane, 3'b000} +: 8] = wdata[7:0];
        end else begin
            merged[{lane[1], 4'b0000} +: 16] = wdata;
        end
        merge_lane = merged;
    endfunction

    // Each memory valid is only cleared by the state that raised it, so exactly one
    // access is made per request and the read and write channels never overlap.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            size_q        <= 2'd0;
            signed_q      <= 1'b0;
            lane_q        <= 2'd0;
            wdata_q       <= 16'd0;
            resp_valid    <= 1'b0;
            resp_data     <= 32'd0;
            resp_error    <= 1'b0;
            mem_in_addr   <= 32'd0;
            mem_in_data   <= 32'd0;
            mem_in_valid  <= 1'b0;
            mem_out_addr  <= 32'd0;
            mem_out_valid <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        size_q   <= req_size;
                        signed_q <= req_signed;
                        lane_q   <= req_addr[1:0];
                        wdata_q  <= req_wdata[15:0];
                        if (req_error) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_error <= 1'b1;
                            resp_data  <= 32'd0;
                        end else begin
                            mem_in_addr  <= {2'b00, word_idx};
                            mem_out_addr <= {2'b00, word_idx};
                            if (!req_write) begin
                                state         <= RD_WAIT;
                                mem_out_valid <= 1'b1;
                            end else if (req_size == 2'd2) begin
                                state        <= WR_WAIT;
                                mem_in_valid <= 1'b1;
                                mem_in_data  <= req_wdata;
                            end else begin
                                state         <= RMW_RD_WAIT;
                                mem_out_valid <= 1'b1;
                            end
                        end
                    end
                end
                RD_WAIT: begin
                    if (mem_out_ready) begin
                        mem_out_valid <= 1'b0;
                        resp_data     <= extract_lane(mem_out_data, size_q, signed_q, lane_q);
                        resp_error    <= 1'b0;
                        resp_valid    <= 1'b1;
                        state         <= RESP;
                    end
                end
                RMW_RD_WAIT: begin
                    if (mem_out_ready) begin
                        mem_out_valid <= 1'b0;
                        mem_in_data   <= merge_lane(mem_out_data, size_q, lane_q, wdata_q);
                        mem_in_valid  <= 1'b1;
                        state         <= WR_WAIT;
                    end
                end
                WR_WAIT: begin
                    if (mem_in_ready) begin
                        mem_in_valid <= 1'b0;
                        resp_data    <= 32'd0;
                        resp_error   <= 1'b0;
                        resp_valid   <= 1'b1;
                        state        <= RESP;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a one-cycle-latency word memory model
// and a negedge monitor for handshakes, valid overlap and response ordering.
module tb_load_store_unit;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        resp_error;
    logic [31:0] mem_in_addr;
    logic [31:0] mem_in_data;
    logic        mem_in_valid;
    logic        mem_in_ready;
    logic [31:0] mem_out_addr;
    logic        mem_out_valid;
    logic [31:0] mem_out_data;
    logic        mem_out_ready;

    logic        mem_in_ready_model;
    logic        in_inject;
    logic        out_prev;
    logic        in_prev;
    logic [31:0] mem [16];

    int checks = 0;
    int errors = 0;
    int cycle_cnt = 0;
    int both_high = 0;
    int valid_cycles = 0;
    int write_count = 0;
    int resp_count = 0;
    logic rec_en = 1'b0;
    int accept_cyc[$];
    int resp_cyc[$];
    logic [31:0] resp_q[$];

    int          res_lat;
    logic [31:0] res_data;
    logic        res_err;
    int          res_wr_cyc;
    logic [31:0] res_wr_addr;

    assign mem_in_ready = mem_in_ready_model | in_inject;

    load_store_unit #(.MEM_BIT_WIDTH(10)) dut (
        .clk(clk),
        .reset(reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_write(req_write),
        .req_size(req_size),
        .req_signed(req_signed),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid),
        .resp_data(resp_data),
        .resp_error(resp_error),
        .mem_in_addr(mem_in_addr),
        .mem_in_data(mem_in_data),
        .mem_in_valid(mem_in_valid),
        .mem_in_ready(mem_in_ready),
        .mem_out_addr(mem_out_addr),
        .mem_out_valid(mem_out_valid),
        .mem_out_data(mem_out_data),
        .mem_out_ready(mem_out_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory answers a valid with a one-cycle ready pulse in the cycle after it first sees it.
    initial begin
        mem_out_ready      = 1'b0;
        mem_in_ready_model = 1'b0;
        mem_out_data       = 32'd0;
        out_prev           = 1'b0;
        in_prev            = 1'b0;
        for (int i = 0; i < 16; i++) mem[i] = 32'd0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_out_valid && out_prev && !mem_out_ready) begin
                mem_out_ready = 1'b1;
                mem_out_data  = mem[mem_out_addr[3:0]];
            end else begin
                mem_out_ready = 1'b0;
            end
            if (mem_in_valid && in_prev && !mem_in_ready_model) begin
                mem_in_ready_model = 1'b1;
                mem[mem_in_addr[3:0]] = mem_in_data;
            end else begin
                mem_in_ready_model = 1'b0;
            end
            out_prev = mem_out_valid;
            in_prev  = mem_in_valid;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            cycle_cnt++;
            if (mem_in_valid && mem_out_valid) both_high++;
            if (mem_in_valid || mem_out_valid) valid_cycles++;
            if (mem_in_valid && mem_in_ready) write_count++;
            if (resp_valid) resp_count++;
            if (rec_en) begin
                if (req_valid && req_ready) accept_cyc.push_back(cycle_cnt);
                if (resp_valid) begin
                    resp_cyc.push_back(cycle_cnt);
                    resp_q.push_back(resp_data);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Issues one request and records response latency (cycle 0 = acceptance) and first write.
    task automatic applyStimulus(input logic wr, input logic [1:0] size, input logic sgn,
                                 input logic [31:0] addr, input logic [31:0] wdata);
        int n;
        @(negedge clk);
        req_write  = wr;
        req_size   = size;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wdata;
        req_valid  = 1'b1;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        req_valid   = 1'b0;
        res_lat     = -1;
        res_data    = 32'hDEAD_BEEF;
        res_err     = 1'bx;
        res_wr_cyc  = -1;
        res_wr_addr = 32'hFFFF_FFFF;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (mem_in_valid && res_wr_cyc < 0) begin
                res_wr_cyc  = c;
                res_wr_addr = mem_in_addr;
            end
            if (resp_valid) begin
                res_lat  = c;
                res_data = resp_data;
                res_err  = resp_error;
                break;
            end
        end
    endtask

    initial begin
        int wc;
        int rc;
        int vc;
        int n;
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_size   = 2'd0;
        req_signed = 1'b0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        in_inject  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_req_ready", {31'd0, req_ready}, 32'd1);
        checkOutput("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        checkOutput("rst_mem_valids", {30'd0, mem_in_valid, mem_out_valid}, 32'd0);
        checkOutput("rst_mem_in_addr", mem_in_addr, 32'd0);
        checkOutput("rst_resp_data", resp_data, 32'd0);
        reset = 1'b0;

        $display("[TB] word store / word load");
        applyStimulus(1'b1, 2'd2, 1'b0, 32'h8, 32'h1122_3344);
        checkOutput("wst_latency", 32'(res_lat), 32'd3);
        checkOutput("wst_write_cycle", 32'(res_wr_cyc), 32'd1);
        checkOutput("wst_write_addr", res_wr_addr, 32'd2);
        checkOutput("wst_error", {31'd0, res_err}, 32'd0);
        applyStimulus(1'b0, 2'd2, 1'b0, 32'h8, 32'd0);
        checkOutput("wld_latency", 32'(res_lat), 32'd3);
        checkOutput("wld_data", res_data, 32'h1122_3344);
        checkOutput("wld_error", {31'd0, res_err}, 32'd0);

        $display("[TB] byte store read-modify-write");
        wc = write_count;
        applyStimulus(1'b1, 2'd0, 1'b0, 32'h9, 32'hFFFF_FFAB);
        checkOutput("bst_latency", 32'(res_lat), 32'd5);
        checkOutput("bst_write_cycle", 32'(res_wr_cyc), 32'd3);
        checkOutput("bst_mem_word", mem[2], 32'h1122_AB44);
        checkOutput("bst_single_write", 32'(write_count - wc), 32'd1);

        $display("[TB] sub-word loads");
        applyStimulus(1'b1, 2'd2, 1'b0, 32'hC, 32'h80F0_7F81);
        checkOutput("pre_latency", 32'(res_lat), 32'd3);
        applyStimulus(1'b0, 2'd0, 1'b1, 32'hC, 32'd0);
        checkOutput("lb_signed", res_data, 32'hFFFF_FF81);
        applyStimulus(1'b0, 2'd0, 1'b0, 32'hC, 32'd0);
        checkOutput("lb_unsigned", res_data, 32'h0000_0081);
        applyStimulus(1'b0, 2'd0, 1'b1, 32'hD, 32'd0);
        checkOutput("lb_signed_pos", res_data, 32'h0000_007F);
        applyStimulus(1'b0, 2'd1, 1'b1, 32'hE, 32'd0);
        checkOutput("lh_signed", res_data, 32'hFFFF_80F0);
        applyStimulus(1'b0, 2'd1, 1'b0, 32'hE, 32'd0);
        checkOutput("lh_unsigned", res_data, 32'h0000_80F0);
        checkOutput("lh_latency", 32'(res_lat), 32'd3);

        $display("[TB] error responses");
        vc = valid_cycles;
        applyStimulus(1'b0, 2'd1, 1'b0, 32'h3, 32'd0);
        checkOutput("err_half_lat", 32'(res_lat), 32'd1);
        checkOutput("err_half_flag", {31'd0, res_err}, 32'd1);
        checkOutput("err_half_data", res_data, 32'd0);
        applyStimulus(1'b1, 2'd2, 1'b0, 32'h6, 32'h1234_5678);
        checkOutput("err_word_lat", 32'(res_lat), 32'd1);
        checkOutput("err_word_flag", {31'd0, res_err}, 32'd1);
        applyStimulus(1'b0, 2'd3, 1'b0, 32'h0, 32'd0);
        checkOutput("err_size_lat", 32'(res_lat), 32'd1);
        checkOutput("err_size_flag", {31'd0, res_err}, 32'd1);
        applyStimulus(1'b0, 2'd2, 1'b0, 32'h1000, 32'd0);
        checkOutput("err_range_lat", 32'(res_lat), 32'd1);
        checkOutput("err_range_flag", {31'd0, res_err}, 32'd1);
        checkOutput("err_range_data", res_data, 32'd0);
        checkOutput("err_no_mem_valid", 32'(valid_cycles - vc), 32'd0);
        applyStimulus(1'b0, 2'd2, 1'b0, 32'hFFC, 32'd0);
        checkOutput("top_index_lat", 32'(res_lat), 32'd3);
        checkOutput("top_index_flag", {31'd0, res_err}, 32'd0);

        $display("[TB] reset during sub-word store");
        wc = write_count;
        rc = resp_count;
        @(negedge clk);
        req_write  = 1'b1;
        req_size   = 2'd0;
        req_signed = 1'b0;
        req_addr   = 32'h15;
        req_wdata  = 32'h5A;
        req_valid  = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("midrst_req_ready", {31'd0, req_ready}, 32'd1);
        checkOutput("midrst_valids", {29'd0, resp_valid, mem_in_valid, mem_out_valid}, 32'd0);
        checkOutput("midrst_addrs", mem_in_addr | mem_out_addr, 32'd0);
        checkOutput("midrst_in_data", mem_in_data, 32'd0);
        checkOutput("midrst_resp", {resp_data[30:0], resp_error}, 32'd0);
        @(posedge clk);
        #1;
        in_inject = 1'b1;
        @(posedge clk);
        #1;
        in_inject = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("stale_req_ready", {31'd0, req_ready}, 32'd1);
        checkOutput("stale_no_write", 32'(write_count - wc), 32'd0);
        checkOutput("stale_no_resp", 32'(resp_count - rc), 32'd0);
        checkOutput("stale_mem_word", mem[5], 32'd0);
        applyStimulus(1'b0, 2'd2, 1'b0, 32'h8, 32'd0);
        checkOutput("post_rst_lat", 32'(res_lat), 32'd3);
        checkOutput("post_rst_data", res_data, 32'h1122_AB44);

        $display("[TB] back-to-back stream");
        rec_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            n = 0;
            @(posedge clk);
            #1;
            while (!req_ready && n < 20) begin
                @(posedge clk);
                #1;
                n++;
            end
            req_write  = (i % 2 == 0);
            req_size   = 2'd2;
            req_signed = 1'b0;
            req_addr   = 32'h10;
            req_wdata  = 32'hA500_0000 | 32'(i);
            req_valid  = 1'b1;
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        n = 0;
        while (resp_q.size() < 6 && n < 30) begin
            @(negedge clk);
            n++;
        end
        rec_en = 1'b0;
        checkOutput("stream_accepts", 32'(accept_cyc.size()), 32'd6);
        checkOutput("stream_resps", 32'(resp_q.size()), 32'd6);
        if (accept_cyc.size() == 6 && resp_q.size() == 6) begin
            for (int i = 0; i < 6; i++) begin
                checkOutput($sformatf("stream_data_%0d", i), resp_q[i],
                            (i % 2 == 0) ? 32'd0 : (32'hA500_0000 | 32'(i - 1)));
                checkOutput($sformatf("stream_lat_%0d", i), 32'(resp_cyc[i] - accept_cyc[i]), 32'd3);
                if (i < 5) begin
                    checkOutput($sformatf("stream_gap_%0d", i), 32'(accept_cyc[i + 1] - resp_cyc[i]), 32'd1);
                end
            end
        end
        checkOutput("never_both_valid", 32'(both_high), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
